// File: rtl/key_line_decoder_pkg.sv
// Shared types, default levels and elaboration helpers for the key line decoder.
// Contents:
//   state_t / slice_t  - decoder FSM and slicer state encodings
//   DEF_*              - default level, width and ID constants
//   calc_spb           - samples per bit for a given line geometry
//   params_ok          - legality of a parameter set
//   maj3               - 2-of-3 majority vote
package key_line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } slice_t;

    localparam int unsigned DEF_DATA_W       = 10;
    localparam int unsigned DEF_BLACK_LEVEL  = 282;
    localparam int unsigned DEF_WHITE_LEVEL  = 966;
    localparam int unsigned DEF_HYST         = 256;
    localparam int unsigned DEF_SAMPLES      = 720;
    localparam int unsigned DEF_TOTAL_BITS   = 40;
    localparam int unsigned DEF_PAYLOAD_BITS = 32;
    localparam int unsigned DEF_ID_BITS      = 8;
    localparam int unsigned DEF_ID_VALUE     = 32'h0000_00A5;

    function automatic int unsigned calc_spb(input int unsigned samples, input int unsigned total);
        return samples / total;
    endfunction

    // Signed arithmetic so a large HYST cannot wrap the white-side threshold.
    function automatic bit params_ok(input int spb, input int total, input int id_bits,
                                     input int payload, input int black, input int white,
                                     input int hyst);
        return (spb >= 3) && (total == id_bits + payload) && ((black + hyst) < (white - hyst));
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/key_line_decoder_if.sv
// Key line bus: luma sample stream in, decoded key and status out.
//   sample_valid, line_start, sample_in : driven by the video source (master)
//   key_out, key_valid, id_error, busy  : driven by the decoder (slave)
interface key_line_decoder_if
    import key_line_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned PAYLOAD_BITS = DEF_PAYLOAD_BITS
);
    logic                    sample_valid;
    logic                    line_start;
    logic [DATA_W-1:0]       sample_in;
    logic [PAYLOAD_BITS-1:0] key_out;
    logic                    key_valid;
    logic                    id_error;
    logic                    busy;

    modport master (
        output sample_valid, line_start, sample_in,
        input  key_out, key_valid, id_error, busy
    );

    modport slave (
        input  sample_valid, line_start, sample_in,
        output key_out, key_valid, id_error, busy
    );
endinterface

// File: rtl/key_line_decoder_slicer.sv
// key_line_slicer: hysteresis comparator turning luma samples into a black/white level.
// Ports:
//   clock, reset_n  - clock, async active-low reset
//   sample_valid    - update the level from sample_in this cycle
//   line_start      - force the level to LOW
//   sample_in       - luma sample
//   level           - registered slicer state (LOW/HIGH)
module key_line_slicer
    import key_line_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned BLACK_LEVEL = DEF_BLACK_LEVEL,
    parameter int unsigned WHITE_LEVEL = DEF_WHITE_LEVEL,
    parameter int unsigned HYST        = DEF_HYST
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic              line_start,
    input  logic [DATA_W-1:0] sample_in,
    output slice_t            level
);

    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(WHITE_LEVEL - HYST);
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(BLACK_LEVEL + HYST);

    slice_t state_q;
    slice_t state_d;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Strict comparisons: a sample exactly on a threshold never switches
    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = LOW;
        end else if (sample_valid) begin
            unique case (state_q)
                LOW:     if (sample_in > HI_TH) state_d = HIGH;
                HIGH:    if (sample_in < LO_TH) state_d = LOW;
                default: state_d = LOW;
            endcase
        end
    end

    assign level = state_q;

endmodule

// File: rtl/key_line_decoder.sv
// key_line_decoder: recovers the scrambler key from a black/white bit pattern
// carried in the luma samples of one dedicated video line.
// Ports:
//   clock, reset_n     - clock, async active-low reset
//   bus (slave)        - sample_valid/line_start/sample_in in;
//                        key_out/key_valid/id_error/busy out (all registered)
// Optional build macro KEY_LINE_MAJORITY_EN: each bit is the 2-of-3 majority of the
// slicer level seen around the bit centre instead of a single decision.
module key_line_decoder
    import key_line_pkg::*;
#(
    parameter int unsigned       DATA_W           = DEF_DATA_W,
    parameter int unsigned       BLACK_LEVEL      = DEF_BLACK_LEVEL,
    parameter int unsigned       WHITE_LEVEL      = DEF_WHITE_LEVEL,
    parameter int unsigned       HYST             = DEF_HYST,
    parameter int unsigned       SAMPLES_PER_LINE = DEF_SAMPLES,
    parameter int unsigned       TOTAL_BITS       = DEF_TOTAL_BITS,
    parameter int unsigned       PAYLOAD_BITS     = DEF_PAYLOAD_BITS,
    parameter int unsigned       ID_BITS          = DEF_ID_BITS,
    parameter logic [ID_BITS-1:0] ID_VALUE        = ID_BITS'(DEF_ID_VALUE)
) (
    input  logic               clock,
    input  logic               reset_n,
    key_line_decoder_if.slave  bus
);

    localparam int unsigned SPB     = calc_spb(SAMPLES_PER_LINE, TOTAL_BITS);
    localparam int unsigned SCNT_W  = $clog2(SPB);
    localparam int unsigned BCNT_W  = $clog2(TOTAL_BITS);
    localparam int unsigned DEC_CNT = SPB / 2 - 1;
`ifdef KEY_LINE_MAJORITY_EN
    localparam int unsigned MAJ_FIRST = SPB / 2 - 2;
    localparam int unsigned SHIFT_CNT = SPB / 2;
`endif

    if (!params_ok(int'(SPB), int'(TOTAL_BITS), int'(ID_BITS), int'(PAYLOAD_BITS),
                   int'(BLACK_LEVEL), int'(WHITE_LEVEL), int'(HYST))) begin : g_param_error
        $error("key_line_decoder: illegal parameter set");
    end

    slice_t level;

    key_line_slicer #(
        .DATA_W      (DATA_W),
        .BLACK_LEVEL (BLACK_LEVEL),
        .WHITE_LEVEL (WHITE_LEVEL),
        .HYST        (HYST)
    ) u_slicer (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (bus.sample_valid),
        .line_start   (bus.line_start),
        .sample_in    (bus.sample_in),
        .level        (level)
    );

    state_t                  state_q,      state_d;
    logic [SCNT_W-1:0]       sample_cnt_q, sample_cnt_d;
    logic [BCNT_W-1:0]       bit_cnt_q,    bit_cnt_d;
    logic [TOTAL_BITS-1:0]   shreg_q,      shreg_d;
    logic [PAYLOAD_BITS-1:0] key_out_q,    key_out_d;
    logic                    key_valid_q,  key_valid_d;
    logic                    id_error_q,   id_error_d;
    logic                    busy_q,       busy_d;
`ifdef KEY_LINE_MAJORITY_EN
    logic [1:0]              maj_q,        maj_d;
`endif

    logic shift_en;
    logic bit_val;

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            key_out_q    <= '0;
            key_valid_q  <= 1'b0;
            id_error_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef KEY_LINE_MAJORITY_EN
            maj_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            key_out_q    <= key_out_d;
            key_valid_q  <= key_valid_d;
            id_error_q   <= id_error_d;
            busy_q       <= busy_d;
`ifdef KEY_LINE_MAJORITY_EN
            maj_q        <= maj_d;
`endif
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        key_out_d    = key_out_q;
        key_valid_d  = 1'b0;
        id_error_d   = 1'b0;
        busy_d       = busy_q;
        shift_en     = 1'b0;
        bit_val      = (level == HIGH);
`ifdef KEY_LINE_MAJORITY_EN
        maj_d        = maj_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.line_start) begin
                    state_d      = RUN;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                    shreg_d      = '0;
                    busy_d       = 1'b1;
                end
            end

            RUN: begin
                if (bus.line_start) begin
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                    shreg_d      = '0;
                end else if (bus.sample_valid) begin
`ifdef KEY_LINE_MAJORITY_EN
                    // Capture the two earlier votes; the third is the live level
                    if (sample_cnt_q == SCNT_W'(MAJ_FIRST)) maj_d[0] = (level == HIGH);
                    if (sample_cnt_q == SCNT_W'(DEC_CNT))   maj_d[1] = (level == HIGH);
                    if (sample_cnt_q == SCNT_W'(SHIFT_CNT)) begin
                        shift_en = 1'b1;
                        bit_val  = maj3(maj_q[0], maj_q[1], (level == HIGH));
                    end
`else
                    if (sample_cnt_q == SCNT_W'(DEC_CNT)) shift_en = 1'b1;
`endif
                    if (shift_en) shreg_d = {shreg_q[TOTAL_BITS-2:0], bit_val};

                    // Last bit decided: the rest of the line is ignored
                    if (shift_en && (bit_cnt_q == BCNT_W'(TOTAL_BITS - 1))) begin
                        state_d = CHECK;
                    end else if (sample_cnt_q == SCNT_W'(SPB - 1)) begin
                        sample_cnt_d = '0;
                        bit_cnt_d    = bit_cnt_q + BCNT_W'(1);
                    end else begin
                        sample_cnt_d = sample_cnt_q + SCNT_W'(1);
                    end
                end
            end

            CHECK: begin
                // A new line_start wins over the verdict of the finished line
                if (bus.line_start) begin
                    state_d      = RUN;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                    shreg_d      = '0;
                end else begin
                    if (shreg_q[TOTAL_BITS-1 -: ID_BITS] == ID_VALUE) begin
                        key_out_d   = shreg_q[PAYLOAD_BITS-1:0];
                        key_valid_d = 1'b1;
                    end else begin
                        id_error_d  = 1'b1;
                    end
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.key_out   = key_out_q;
    assign bus.key_valid = key_valid_q;
    assign bus.id_error  = id_error_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_key_line_decoder.sv
// Self-checking bench for key_line_decoder: directed lines from the test plan plus
// randomized noisy lines checked against a sample-level reference model.
`timescale 1ns/1ps
module tb_key_line_decoder;

    localparam int SPL     = 720;
    localparam int NBITS   = 40;
    localparam int SPB     = SPL / NBITS;
    localparam int HI_TH   = 966 - 256;
    localparam int LO_TH   = 282 + 256;
`ifdef KEY_LINE_MAJORITY_EN
    localparam bit MAJ     = 1'b1;
    localparam int DEC_IDX = SPB / 2;
`else
    localparam bit MAJ     = 1'b0;
    localparam int DEC_IDX = SPB / 2 - 1;
`endif
    localparam int LAST_DEC = (NBITS - 1) * SPB + DEC_IDX;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    key_line_decoder_if #(.DATA_W(10), .PAYLOAD_BITS(32)) bus();

    key_line_decoder dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int kv_cnt    = 0;
    int ie_cnt    = 0;
    int both_cnt  = 0;
    int pulse_cyc = -100;
    int dec_cyc   = 0;
    logic busy_at_start;

    int line_q[$];
    int lvl[NBITS];

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled between active edges
    always @(negedge clock) begin
        if (bus.key_valid === 1'b1) begin
            kv_cnt++;
            pulse_cyc = cyc;
        end
        if (bus.id_error === 1'b1) begin
            ie_cnt++;
            pulse_cyc = cyc;
        end
        if (bus.key_valid === 1'b1 && bus.id_error === 1'b1) both_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic word_to_levels(input logic [39:0] word);
        for (int b = 0; b < NBITS; b++) lvl[b] = word[39-b] ? 966 : 282;
    endtask

    // mode 0: clean levels, 1: noisy levels, 2: zero glitch near each payload bit centre
    task automatic build_line(input int mode);
        int v;
        line_q.delete();
        for (int b = 0; b < NBITS; b++) begin
            for (int s = 0; s < SPB; s++) begin
                v = lvl[b];
                if (mode == 1) begin
                    v = (lvl[b] > 600) ? int'($urandom_range(720, 1023)) : int'($urandom_range(0, 530));
                    if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, 1023));
                end
                if (mode == 2 && b >= 8 && s == SPB / 2 - 2) v = 0;
                line_q.push_back(v);
            end
        end
    endtask

    // Reference: hysteresis level before each sample, then bit = level seen at the
    // decision sample (or majority of the three levels around it).
    function automatic logic [39:0] model_word();
        int pre[$];
        int st;
        int d;
        int votes;
        logic [39:0] w;
        st = 0;
        w  = '0;
        foreach (line_q[i]) begin
            pre.push_back(st);
            if (st == 0 && line_q[i] > HI_TH) st = 1;
            else if (st == 1 && line_q[i] < LO_TH) st = 0;
        end
        for (int b = 0; b < NBITS; b++) begin
            d = b * SPB + SPB / 2 - 1;
            if (MAJ) begin
                votes = pre[d-1] + pre[d] + pre[d+1];
                w[39-b] = (votes >= 2);
            end else begin
                w[39-b] = (pre[d] != 0);
            end
        end
        return w;
    endfunction

    // gap < 0 selects a random 0..2 idle cycles between samples
    task automatic send_line(input int n, input int gap);
        @(negedge clock);
        bus.line_start   = 1'b1;
        bus.sample_valid = 1'b0;
        @(negedge clock);
        bus.line_start   = 1'b0;
        busy_at_start    = bus.busy;
        for (int i = 0; i < n; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 10'(line_q[i]);
            if (i == LAST_DEC) dec_cyc = cyc;
            @(negedge clock);
            bus.sample_valid = 1'b0;
            repeat ((gap < 0) ? int'($urandom_range(0, 2)) : gap) @(negedge clock);
        end
    endtask

    task automatic finish_line(input string tag, input int kv0, input int ie0,
                               input int exp_kv, input int exp_ie, input logic [31:0] exp_key);
        repeat (4) @(negedge clock);
        check({tag, "_kv"},   64'(kv_cnt - kv0), 64'(exp_kv));
        check({tag, "_ie"},   64'(ie_cnt - ie0), 64'(exp_ie));
        check({tag, "_key"},  64'(bus.key_out), 64'(exp_key));
        check({tag, "_lat"},  64'(pulse_cyc - dec_cyc), 64'd2);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int kv0, ie0;
        logic [31:0] prev_key, pay;
        logic [7:0]  id;
        logic [39:0] w;

        bus.sample_valid = 1'b0;
        bus.line_start   = 1'b0;
        bus.sample_in    = '0;
        repeat (3) @(negedge clock);
        check("rst_key",   64'(bus.key_out),   64'd0);
        check("rst_kv",    64'(bus.key_valid), 64'd0);
        check("rst_ie",    64'(bus.id_error),  64'd0);
        check("rst_busy",  64'(bus.busy),      64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Valid line
        kv0 = kv_cnt; ie0 = ie_cnt;
        word_to_levels({8'hA5, 32'hDEADBEEF});
        build_line(0);
        send_line(SPL, 1);
        check("valid_busy_run", 64'(busy_at_start), 64'd1);
        finish_line("valid", kv0, ie0, 1, 0, 32'hDEADBEEF);

        // ID mismatch keeps the previous key
        kv0 = kv_cnt; ie0 = ie_cnt;
        word_to_levels({8'hA4, 32'h12345678});
        build_line(0);
        send_line(SPL, 1);
        finish_line("idmis", kv0, ie0, 0, 1, 32'hDEADBEEF);

        // Hysteresis: 700 follows the previous level, 710 and 538 do not switch
        kv0 = kv_cnt; ie0 = ie_cnt;
        word_to_levels({8'hA5, 32'h0});
        lvl[8]  = 966;  lvl[9]  = 700;
        lvl[10] = 282;  lvl[11] = 700;
        lvl[12] = 710;
        lvl[13] = 966;  lvl[14] = 538;
        build_line(0);
        send_line(SPL, 1);
        finish_line("hyst", kv0, ie0, 1, 0, 32'hC6000000);

        // Abort at bit 20, then a full line
        kv0 = kv_cnt; ie0 = ie_cnt;
        word_to_levels({8'hA5, 32'hDEADBEEF});
        build_line(0);
        send_line(20 * SPB, 1);
        word_to_levels({8'hA5, 32'h0BADF00D});
        build_line(0);
        send_line(SPL, 1);
        finish_line("abort", kv0, ie0, 1, 0, 32'h0BADF00D);

        // Asynchronous reset at bit 30
        word_to_levels({8'hA5, 32'hCAFEF00D});
        build_line(0);
        send_line(30 * SPB, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_key",  64'(bus.key_out),   64'd0);
        check("arst_busy", 64'(bus.busy),      64'd0);
        check("arst_kv",   64'(bus.key_valid), 64'd0);
        check("arst_ie",   64'(bus.id_error),  64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        kv0 = kv_cnt; ie0 = ie_cnt;
        pay = $urandom();
        word_to_levels({8'hA5, pay});
        build_line(0);
        send_line(SPL, 1);
        finish_line("post_rst", kv0, ie0, 1, 0, pay);

        // Glitch near each payload bit centre
        kv0 = kv_cnt; ie0 = ie_cnt;
        word_to_levels({8'hA5, 32'hFFFFFFFF});
        build_line(2);
        send_line(SPL, 1);
        finish_line("glitch", kv0, ie0, 1, 0, MAJ ? 32'hFFFFFFFF : 32'h00000000);

        // Randomized noisy lines against the reference model
        for (int n = 0; n < 6; n++) begin
            kv0 = kv_cnt; ie0 = ie_cnt;
            prev_key = bus.key_out;
            id  = ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'($urandom());
            pay = $urandom();
            word_to_levels({id, pay});
            build_line(1);
            w = model_word();
            send_line(SPL, -1);
            if (w[39:32] == 8'hA5) finish_line($sformatf("rand%0d", n), kv0, ie0, 1, 0, w[31:0]);
            else                   finish_line($sformatf("rand%0d", n), kv0, ie0, 0, 1, prev_key);
        end

        check("never_both", 64'(both_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_line_decoder.md
Name: key_line_decoder

Overview:
- Recovers the scrambler key from one dedicated video line. On that line the key is carried as a black/white bit pattern in the luma samples coming from the TVP5147M1 decoder interface.
- Replaces the derived-clock detector. The block runs entirely on `clock`, uses a per-sample qualifier instead of an internal toggle, and is generalised in line length, bit count and ID width.
- Requires an exact ID match before releasing a key to the descrambler.

Parameters:
- DATA_W, 10, luma sample width
- BLACK_LEVEL, 282, nominal black code
- WHITE_LEVEL, 966, nominal white code
- HYST, 256, hysteresis offset applied to both levels
- SAMPLES_PER_LINE, 720, active luma samples per line
- TOTAL_BITS, 40, bits per key line, ID + payload
- PAYLOAD_BITS, 32, key bits, LSBs of the received word
- ID_BITS, 8, ID field width (TOTAL_BITS = ID_BITS + PAYLOAD_BITS)
- ID_VALUE, 8'hA5, expected ID field

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset
- sample_valid  in  1  sample_in carries a luma sample this cycle
- line_start  in  1  one-cycle pulse, first active sample of the key line follows
- sample_in  in  DATA_W  luma sample
- key_out  out  PAYLOAD_BITS  last accepted key
- key_valid  out  1  one-cycle pulse, new key accepted
- id_error  out  1  one-cycle pulse, line decoded but ID mismatched
- busy  out  1  line capture in progress

Behaviour:
- Reset is asynchronous, active-low on reset_n. The block is clocked on the rising edge of clock. No derived or gated clocks.
- Reset values:
  - key_out = 0, key_valid = 0, id_error = 0, busy = 0
  - FSM = IDLE, slicer state = LOW, all counters = 0
- SPB = SAMPLES_PER_LINE / TOTAL_BITS (default 18), computed at elaboration.
- Elaboration error if any of:
  - SPB < 3
  - TOTAL_BITS != ID_BITS + PAYLOAD_BITS
  - BLACK_LEVEL + HYST >= WHITE_LEVEL - HYST
- Slicer, evaluated only on sample_valid cycles:
  - LOW -> HIGH when sample_in > WHITE_LEVEL - HYST (strict)
  - HIGH -> LOW when sample_in < BLACK_LEVEL + HYST (strict)
  - otherwise the state holds
  - The slicer is forced to LOW on line_start.
- Counters: sample_cnt runs 0..SPB-1; bit_cnt is $clog2(TOTAL_BITS) wide. Both advance only on sample_valid while in RUN.
- Bit decision is taken on the sample_valid cycle where sample_cnt == SPB/2 - 1. The registered slicer output is shifted into shreg[TOTAL_BITS-1:0], MSB first: the first bit ends in shreg[TOTAL_BITS-1].
- FSM:
  - IDLE: line_start -> RUN; counters cleared, busy = 1 next cycle.
  - RUN: when bit index TOTAL_BITS-1 reaches its decision point -> CHECK. Remaining samples on the line are ignored.
  - CHECK, single cycle:
    - If shreg[TOTAL_BITS-1 -: ID_BITS] == ID_VALUE (exact equality, not a mask), then key_out <= shreg[PAYLOAD_BITS-1:0] and key_valid pulses.
    - Otherwise id_error pulses and key_out holds.
    - Then -> IDLE, busy = 0.
- Latency: key_valid asserts 2 clocks after the sample_valid edge of the last decision sample.
- line_start in RUN or CHECK aborts the capture and restarts RUN. No pulse is emitted, key_out holds, and line_start has priority over the CHECK result.
- sample_valid = 0 cycles stall the counters and slicer; there is no timeout.
- An asynchronous reset mid-line discards the partial word immediately.
- key_valid and id_error are never asserted in the same cycle.

Optional Feature:
- Macro KEY_LINE_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of the slicer output at sample_cnt = SPB/2-2, SPB/2-1 and SPB/2. The shift happens on the SPB/2 sample, so latency grows by one sample period.
- Undefined: a single decision at SPB/2-1 as above.

Decomposition:
- Package key_line_pkg holds:
  - FSM state typedef (IDLE, RUN, CHECK)
  - default level constants
  - default ID_VALUE
  - function computing SPB plus the elaboration checks
- One sub-module, key_line_slicer: the hysteresis comparator with its own state register, plus sample_valid and line_start inputs.

Test Plan:
- Valid line: ID 0xA5 and payload 0xDEADBEEF, each bit as 18 samples of 966 (1) or 282 (0), sample_valid every other clock -> one key_valid pulse, key_out = 0xDEADBEEF, id_error = 0.
- ID mismatch: ID 0xA4, payload 0x12345678 -> id_error pulse, key_out keeps its previous value, no key_valid.
- Hysteresis:
  - A bit of samples at 700 after HIGH -> decodes 1.
  - The same 700 level after LOW -> decodes 0.
  - Values 710 (= threshold) and 538 do not switch.
- Abort: line_start at bit 20, then a full valid line with 0x0BADF00D -> exactly one key_valid, key_out = 0x0BADF00D.
- Reset: reset_n low at bit 30 -> all outputs 0 immediately; the following full line decodes correctly.
- With KEY_LINE_MAJORITY_EN: one glitch sample of 0 at each bit centre of an all-ones payload -> key_out = 0xFFFFFFFF. Without the macro, the same stimulus yields 0x00000000.
